addbit_pipe: RTL and testbench
==============================

# addbit_pipe

Parametrised, pipelined successor to the 1-bit gate-level adder `addbit` used in the `top` bench. It adds or subtracts two WIDTH-bit operands with carry/borrow-in, splitting the carry chain into STAGES equal chunks with one register stage per chunk. Operands and results move through valid/ready handshakes, so the block can sit behind the co-simulation stimulus path and drive result checking under backpressure.

## Interface
Parameters:
- WIDTH, 32, operand width; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; chunk width CW = WIDTH/STAGES; STAGES >= 1.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts the beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: a+b+ci; 1: a-b-ci.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- co  output  1  carry-out; when sub=1, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- Operand transform at entry: bx = sub ? ~b : b; cx = sub ? ~ci : ci. The result is always a + bx + cx.
- Stage k (0..STAGES-1) adds chunk k, bits [k*CW +: CW], of a and bx plus the carry registered by stage k-1. Stage 0 uses cx.
- Each stage register holds:
  - the sum chunks computed so far;
  - the unprocessed upper chunks of a and bx;
  - the running carry;
  - the sign bits a[WIDTH-1] and bx[WIDTH-1];
  - a valid bit.
- Output values:
  - sum is the concatenation of all chunks.
  - co is the final carry.
  - ovf = (a_msb == bx_msb) && (sum[WIDTH-1] != a_msb).
- Stall rule: stall = out_valid && !out_ready. While stall is high:
  - every stage register holds its value;
  - in_ready = 0.
  - Otherwise in_ready = 1 and all stages advance.
- No bubble collapsing. An empty stage advances like a full one.
- A beat is accepted when in_valid && in_ready. If in_valid=0 while advancing, a bubble (valid=0) enters stage 0.
- Result transfers when out_valid && out_ready.
- in_ready depends only on registered out_valid and the out_ready input. There is no combinational path from in_valid to in_ready.
- STAGES=1 degenerates to a single registered adder with the same handshake.

## Timing
- Reset (async assert, sampled on deassert):
  - all valid bits 0, so out_valid=0;
  - sum=0, co=0, ovf=0;
  - in_ready=1 during and after reset.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. visible in the cycle following edge N+STAGES-1. This holds when there is no stall.
- Throughput: 1 beat/cycle while out_ready=1.
- Outputs are registered and held stable while out_valid && !out_ready.
- Simultaneous accept and output transfer in the same cycle is legal and required.
- Reset mid-operation: all in-flight beats are discarded; no partial result is ever presented.
- out_ready may be high while out_valid=0; this has no effect.
- Downstream may deassert out_ready at any time. Upstream must hold a, b, ci and sub only while in_valid && !in_ready.

## Test plan
All scenarios use WIDTH=32, STAGES=4.
- Reset: assert rst mid-stream with 3 beats in flight, release -> out_valid=0, sum=0, co=0, in_ready=1; none of the 3 beats ever emerges.
- Add with full carry ripple: a=32'hFFFF_FFFF, b=0, ci=1, sub=0 -> 4 cycles later sum=0, co=1, ovf=0. Then a=32'h7FFF_FFFF, b=1, ci=0 -> sum=32'h8000_0000, co=0, ovf=1.
- Subtract: a=5, b=7, ci=0, sub=1 -> sum=32'hFFFF_FFFE, co=0 (borrow), ovf=0. Then a=32'h8000_0000, b=1, ci=0 -> sum=32'h7FFF_FFFF, co=1, ovf=1.
- Back-to-back stream: 100 random beats, in_valid=1 and out_ready=1 continuously -> one result per cycle after a 4-cycle fill; order preserved; every result matches the reference model (a ± b ± ci, co, ovf).
- Backpressure: random out_ready at 30% duty with random in_valid -> no beat lost or duplicated, outputs stable while stalled, in_ready low exactly when out_valid && !out_ready.
- Degenerate configs: rerun the stream test at WIDTH=8, STAGES=1 and WIDTH=8, STAGES=8 -> latency 1 and 8 cycles respectively, and all results correct.

Source files
------------

// File: rtl/addbit_pipe.sv
// -----------------------------------------------------------------------------
// addbit_pipe
//
// Pipelined add/subtract unit. The WIDTH-bit carry chain is cut into STAGES
// equal chunks of CW = WIDTH/STAGES bits, and each chunk gets its own register
// stage. Stage k adds chunk k of the operands plus the carry registered by
// stage k-1. Stage 0 uses the transformed carry-in.
//
// Subtraction is folded into the same adder at entry:
//   bx = sub ? ~b : b
//   cx = sub ? ~ci : ci
//   result = a + bx + cx
// When sub=1, co=1 therefore means "no borrow".
//
// Data layout: chunk j's operand bits travel through a delay line of depth j
// until stage j consumes them. From that point the chunk's sum bits travel
// through a delay line of depth STAGES-j until they reach the output. A stage
// register therefore holds the sum chunks already computed plus the upper
// operand chunks still waiting to be added. It also holds the running carry,
// both sign bits and a valid bit.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle; low only while the output is stalled
//   a, b       WIDTH-bit operands
//   ci         carry-in (add) / borrow-in (sub)
//   sub        0: a+b+ci   1: a-b-ci
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   sum        result modulo 2^WIDTH
//   co         carry-out (no-borrow when sub=1)
//   ovf        two's-complement signed overflow
// -----------------------------------------------------------------------------
module addbit_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  logic [WIDTH-1:0] bx;
  logic             cx;
  logic             advance;

  // Per-stage control bits.
  // Entry 0 is the live input. Entry k+1 is the register written by stage k.
  // Entry STAGES is therefore the output stage.
  logic [STAGES:0]  carry_pipe;
  logic [STAGES:0]  valid_pipe;
  logic [STAGES:0]  a_msb_pipe;
  logic [STAGES:0]  bx_msb_pipe;

  assign bx = sub ? ~b : b;
  assign cx = sub ? ~ci : ci;

  assign carry_pipe[0]  = cx;
  assign valid_pipe[0]  = in_valid;
  assign a_msb_pipe[0]  = a[WIDTH-1];
  assign bx_msb_pipe[0] = bx[WIDTH-1];

  assign out_valid = valid_pipe[STAGES];
  assign co        = carry_pipe[STAGES];

  // The whole pipe moves as one unit. Empty stages are not collapsed, so the
  // only stall source is a held result at the output. This keeps in_ready a
  // function of registered state and out_ready only.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  assign ovf = (a_msb_pipe[STAGES] == bx_msb_pipe[STAGES]) &&
               (sum[WIDTH-1] != a_msb_pipe[STAGES]);

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [CW-1:0] op_a;
      logic [CW-1:0] op_b;
      logic [CW:0]   chunk_add;

      logic          carry_q;
      logic          carry_d;
      logic          valid_q;
      logic          valid_d;
      logic          a_msb_q;
      logic          a_msb_d;
      logic          bx_msb_q;
      logic          bx_msb_d;

      // Sum chunk gi is produced in stage gi.
      // It then rides along until the last stage.
      logic [CW-1:0] sum_q [STAGES-gi];
      logic [CW-1:0] sum_d [STAGES-gi];

      if (gi == 0) begin : g_direct
        assign op_a = a[CW-1:0];
        assign op_b = bx[CW-1:0];
      end else begin : g_delayed
        // Operand chunk gi waits gi cycles.
        // This lines it up with the carry coming out of stage gi-1.
        logic [CW-1:0] a_dly_q  [gi];
        logic [CW-1:0] a_dly_d  [gi];
        logic [CW-1:0] bx_dly_q [gi];
        logic [CW-1:0] bx_dly_d [gi];

        always_comb begin
          for (int m = 0; m < gi; m++) begin
            a_dly_d[m]  = a_dly_q[m];
            bx_dly_d[m] = bx_dly_q[m];
          end
          if (advance) begin
            a_dly_d[0]  = a[gi*CW +: CW];
            bx_dly_d[0] = bx[gi*CW +: CW];
            for (int m = 1; m < gi; m++) begin
              a_dly_d[m]  = a_dly_q[m-1];
              bx_dly_d[m] = bx_dly_q[m-1];
            end
          end
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int m = 0; m < gi; m++) begin
              a_dly_q[m]  <= '0;
              bx_dly_q[m] <= '0;
            end
          end else begin
            for (int m = 0; m < gi; m++) begin
              a_dly_q[m]  <= a_dly_d[m];
              bx_dly_q[m] <= bx_dly_d[m];
            end
          end
        end

        assign op_a = a_dly_q[gi-1];
        assign op_b = bx_dly_q[gi-1];
      end

      assign chunk_add = {1'b0, op_a} + {1'b0, op_b} + {{CW{1'b0}}, carry_pipe[gi]};

      always_comb begin
        carry_d  = carry_q;
        valid_d  = valid_q;
        a_msb_d  = a_msb_q;
        bx_msb_d = bx_msb_q;
        for (int m = 0; m < STAGES - gi; m++) begin
          sum_d[m] = sum_q[m];
        end
        if (advance) begin
          carry_d  = chunk_add[CW];
          valid_d  = valid_pipe[gi];
          a_msb_d  = a_msb_pipe[gi];
          bx_msb_d = bx_msb_pipe[gi];
          sum_d[0] = chunk_add[CW-1:0];
          for (int m = 1; m < STAGES - gi; m++) begin
            sum_d[m] = sum_q[m-1];
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          carry_q  <= 1'b0;
          valid_q  <= 1'b0;
          a_msb_q  <= 1'b0;
          bx_msb_q <= 1'b0;
          for (int m = 0; m < STAGES - gi; m++) begin
            sum_q[m] <= '0;
          end
        end else begin
          carry_q  <= carry_d;
          valid_q  <= valid_d;
          a_msb_q  <= a_msb_d;
          bx_msb_q <= bx_msb_d;
          for (int m = 0; m < STAGES - gi; m++) begin
            sum_q[m] <= sum_d[m];
          end
        end
      end

      assign carry_pipe[gi+1]  = carry_q;
      assign valid_pipe[gi+1]  = valid_q;
      assign a_msb_pipe[gi+1]  = a_msb_q;
      assign bx_msb_pipe[gi+1] = bx_msb_q;

      assign sum[gi*CW +: CW] = sum_q[STAGES-1-gi];
    end
  endgenerate

endmodule

// File: tb/tb_addbit_pipe.sv
`timescale 1ns/1ps
module tb_addbit_pipe;

  localparam int NCFG = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        ci;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;

  logic [NCFG-1:0]       ready_o;
  logic [NCFG-1:0]       valid_o;
  logic [NCFG-1:0]       co_o;
  logic [NCFG-1:0]       ovf_o;
  logic [NCFG-1:0][31:0] sum_o;

  int total = 0;
  int bad   = 0;
  bit lat_chk = 1'b1;
  bit end_chk = 1'b0;

  typedef struct {
    logic [31:0] s;
    bit          co;
    bit          ov;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          ci;
    bit          sub;
    logic [31:0] s;
    bit          co;
    bit          ov;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic at width w.
  function automatic exp_t ref_model(input logic [31:0] av, input logic [31:0] bv,
                                     input bit civ, input bit subv, input int w);
    longint mod;
    longint ua;
    longint ub;
    longint full;
    longint sa;
    longint sb;
    longint sr;
    exp_t   e;
    mod = longint'(1) << w;
    ua  = longint'({32'b0, av}) & (mod - 1);
    ub  = longint'({32'b0, bv}) & (mod - 1);
    if (!subv) begin
      full = ua + ub + longint'(civ);
      e.co = (full >= mod);
    end else begin
      full = ua - ub - longint'(civ);
      e.co = (full >= 0);
      if (full < 0) full = full + mod;
    end
    e.s = 32'(full % mod);
    sa  = (ua >= mod / 2) ? ua - mod : ua;
    sb  = (ub >= mod / 2) ? ub - mod : ub;
    sr  = subv ? (sa - sb - longint'(civ)) : (sa + sb + longint'(civ));
    e.ov  = (sr < -(mod / 2)) || (sr >= mod / 2);
    e.cyc = 0;
    return e;
  endfunction

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int W = (gi == 0) ? 32 : 8;
    localparam int S = (gi == 0) ? 4 : ((gi == 1) ? 1 : 8);

    logic [W-1:0] sum_w;
    logic         ir;
    logic         ov;
    logic         co_w;
    logic         ovf_w;

    exp_t         q[$];
    exp_t         e;
    int           cyc = 0;
    bit           stall_prev = 1'b0;
    bit           end_done = 1'b0;
    logic [W-1:0] sum_prev;
    logic         co_prev;
    logic         ovf_prev;

    addbit_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir),
      .a         (a[W-1:0]),
      .b         (b[W-1:0]),
      .ci        (ci),
      .sub       (sub),
      .out_valid (ov),
      .out_ready (out_ready),
      .sum       (sum_w),
      .co        (co_w),
      .ovf       (ovf_w)
    );

    assign ready_o[gi] = ir;
    assign valid_o[gi] = ov;
    assign co_o[gi]    = co_w;
    assign ovf_o[gi]   = ovf_w;
    assign sum_o[gi]   = 32'(sum_w);

    // Per-instance scoreboard.
    // Samples 2 ns after the driver's falling-edge updates.
    always @(negedge clk) begin
      #2;
      if (rst) begin
        q.delete();
        stall_prev = 1'b0;
        cyc = 0;
      end else begin
        cyc++;
        check($sformatf("in_ready[cfg%0d]", gi), ir, !(ov && !out_ready));
        if (stall_prev) begin
          check($sformatf("hold_valid[cfg%0d]", gi), ov, 1);
          check($sformatf("hold_sum[cfg%0d]", gi), sum_w, sum_prev);
          check($sformatf("hold_co[cfg%0d]", gi), co_w, co_prev);
          check($sformatf("hold_ovf[cfg%0d]", gi), ovf_w, ovf_prev);
        end
        if (ov && out_ready) begin
          check($sformatf("result_expected[cfg%0d]", gi), q.size() > 0, 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("sum[cfg%0d]", gi), sum_w, e.s);
            check($sformatf("co[cfg%0d]", gi), co_w, e.co);
            check($sformatf("ovf[cfg%0d]", gi), ovf_w, e.ov);
            if (lat_chk) check($sformatf("latency[cfg%0d]", gi), cyc - e.cyc, S);
          end
        end
        if (in_valid && ir) begin
          e = ref_model(a, b, ci, sub, W);
          e.cyc = cyc;
          q.push_back(e);
        end
        stall_prev = ov && !out_ready;
        sum_prev = sum_w;
        co_prev  = co_w;
        ovf_prev = ovf_w;
        if (end_chk && !end_done) begin
          check($sformatf("drained[cfg%0d]", gi), q.size(), 0);
          end_done = 1'b1;
        end
      end
    end
  end

  task automatic rand_beat();
    a   = $urandom;
    b   = $urandom;
    ci  = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) b = ~a;
    if ($urandom_range(0, 7) == 0) a = 32'h7FFF_FFFF;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, ready_o[0], 1);
    check({tag, "_out_valid"}, valid_o[0], 0);
    check({tag, "_sum"}, sum_o[0], 0);
    check({tag, "_co"}, co_o[0], 0);
    check({tag, "_ovf"}, ovf_o[0], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int   waited;
    int   seen;
    bit   pending;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    ci = 1'b0;
    sub = 1'b0;

    // Reset state while reset is held.
    repeat (2) @(negedge clk);
    #3;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;
    #3;
    check_reset_state("post_reset");

    // Directed vectors, one beat at a time.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = vecs[i].a;
      b = vecs[i].b;
      ci = vecs[i].ci;
      sub = vecs[i].sub;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      waited = 1;
      #3;
      while (!valid_o[0] && waited < 20) begin
        @(negedge clk);
        #3;
        waited++;
      end
      check($sformatf("dir%0d_latency", i), waited, 4);
      check($sformatf("dir%0d_sum", i), sum_o[0], vecs[i].s);
      check($sformatf("dir%0d_co", i), co_o[0], vecs[i].co);
      check($sformatf("dir%0d_ovf", i), ovf_o[0], vecs[i].ov);
    end

    // Mid-stream reset with 3 beats in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      rand_beat();
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #3;
    check_reset_state("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      #3;
      if (valid_o[0]) seen++;
    end
    check("reset_flush", seen, 0);

    // Back-to-back stream of 100 random beats with no backpressure.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      out_ready = 1'b1;
      rand_beat();
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);

    // Backpressure: out_ready about 30% high, in_valid random.
    // Each beat is held until the 32-bit instance accepts it.
    lat_chk = 1'b0;
    pending = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 99) < 30);
      if (!pending) begin
        in_valid = 1'($urandom_range(0, 1));
        rand_beat();
      end
      #1;
      pending = in_valid && !ready_o[0];
    end

    // Drain the pipes, then confirm every scoreboard is empty.
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (15) @(negedge clk);
    end_chk = 1'b1;
    repeat (2) @(negedge clk);
    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
